// File: rtl/snd_pdm_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : snd_pdm_decoder
// Description : Boxcar decimator for a 1-bit PDM/PWM audio stream. Counts
//               the ones seen over each window of DECIM clocks and offers
//               the count as a PCM sample on a valid/ready interface. A
//               sticky overrun flag records samples lost to a slow consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module snd_pdm_decoder #(
  parameter  int DECIM       = 256,
  parameter  int SYNC_STAGES = 2,
  localparam int OUT_BITS    = $clog2(DECIM + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                snd_in,
  output logic [OUT_BITS-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                clr_overrun
);

  // Phase counter only needs to reach DECIM-1; the accumulator and sample
  // use OUT_BITS so a full-ones window (DECIM) is representable.
  localparam int                 PH_BITS = (DECIM > 2) ? $clog2(DECIM) : 1;
  localparam logic [PH_BITS-1:0] PH_LAST = PH_BITS'(DECIM - 1);
  localparam logic [PH_BITS-1:0] PH_ONE  = PH_BITS'(1);

  // Input synchronizer chain; the last stage is the bit that gets counted.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_bit;
  logic [OUT_BITS-1:0]    s_bit_ext;

  // Window state.
  logic [PH_BITS-1:0]     phase_q;
  logic [PH_BITS-1:0]     phase_d;
  logic [OUT_BITS-1:0]    acc_q;
  logic [OUT_BITS-1:0]    acc_d;
  logic [OUT_BITS-1:0]    win_sum;
  logic                   win_done;

  // Output side state.
  logic [OUT_BITS-1:0]    sample_q;
  logic [OUT_BITS-1:0]    sample_d;
  logic                   valid_q;
  logic                   valid_d;
  logic                   overrun_q;
  logic                   overrun_d;
  logic                   accept;
  logic                   ovr_set;

  // --------------------------------------------------------------------------
  // Synchronizer next-state: shift snd_in into the chain every cycle, with
  // no dependence on en so the pipeline is already full when decoding starts.
  // --------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      // Single stage: the flop simply samples the raw input.
      always_comb sync_d = snd_in;
    end else begin : g_sync_chain
      // Multi-stage: shift toward the MSB, which feeds the counter.
      always_comb sync_d = {sync_q[SYNC_STAGES-2:0], snd_in};
    end
  endgenerate

  assign s_bit     = sync_q[SYNC_STAGES-1];
  assign s_bit_ext = {{(OUT_BITS-1){1'b0}}, s_bit};

  // --------------------------------------------------------------------------
  // Window counter: accumulate ones until the last phase, where the running
  // count plus the final bit becomes the window result. Dropping en discards
  // the partial window so the next window starts cleanly at phase 0.
  // --------------------------------------------------------------------------
  always_comb begin
    win_done = 1'b0;
    phase_d  = phase_q;
    acc_d    = acc_q;
    // acc never exceeds DECIM-1 here, so the sum fits in OUT_BITS.
    win_sum  = acc_q + s_bit_ext;
    if (en) begin
      if (phase_q == PH_LAST) begin
        win_done = 1'b1;
        phase_d  = '0;
        acc_d    = '0;
      end else begin
        phase_d  = phase_q + PH_ONE;
        acc_d    = win_sum;
      end
    end else begin
      phase_d = '0;
      acc_d   = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Output handshake: a completed window always lands in the output register.
  // It only counts as an overrun when the previous value was still pending and
  // is not being taken on this same edge. Set beats clear for the sticky flag.
  // --------------------------------------------------------------------------
  always_comb begin
    accept    = valid_q & sample_ready;
    ovr_set   = win_done & valid_q & ~sample_ready;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (win_done) begin
      sample_d = win_sum;
      valid_d  = 1'b1;
    end else if (accept) begin
      valid_d  = 1'b0;
    end

    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers with asynchronous reset; reset drops any partial window.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      phase_q   <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire
